// File: rtl/sr_cmd_seq.sv
// Command sequencer feeding an SR flip-flop: buffers set/reset/spacer commands
// and replays them as fixed-width, mutually exclusive s/r pulses with an idle gap.
//
// state | meaning
// IDLE  | waiting; pops the FIFO head on any edge where count != 0
// DRIVE | s or r (or neither, for a spacer) held for HOLD cycles
// SPACE | outputs low for GAP cycles before returning to IDLE
module sr_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 2,
    parameter int GAP   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    input  logic [1:0]                 cmd_op,
    output logic                       cmd_ready,
    output logic                       s,
    output logic                       r,
    output logic                       busy,
    output logic                       err,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, SPACE} state_t;

    state_t          state;
    logic [1:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [HW-1:0]   hold_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            full;
    logic            accept;
    logic            push;
    logic            pop;
    logic [1:0]      head;

    assign full      = (count == CW'(DEPTH));
    assign cmd_ready = !full && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign push      = accept && (cmd_op != 2'b11);
    assign pop       = (state == IDLE) && (count != '0);
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE) || (count != '0);

    // FIFO storage and occupancy; illegal ops complete the handshake but are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= cmd_op;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            if (accept && (cmd_op == 2'b11))
                err <= 1'b1;
        end
    end

    // s and r are loaded from a single decoded op, so they can never both be high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            s        <= 1'b0;
            r        <= 1'b0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= DRIVE;
                        hold_cnt <= HW'(HOLD - 1);
                        s        <= (head == 2'b01);
                        r        <= (head == 2'b10);
                    end
                end
                DRIVE: begin
                    if (hold_cnt == '0) begin
                        s <= 1'b0;
                        r <= 1'b0;
                        if (GAP > 0) begin
                            state   <= SPACE;
                            gap_cnt <= GW'(GAP - 1);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
                end
                SPACE: begin
                    if (gap_cnt == '0)
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt - GW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_cmd_seq.sv
// Directed bench for sr_cmd_seq with DEPTH=4, HOLD=2, GAP=1; expected values
// are hand-derived cycle by cycle from the command-to-pulse timing.
module tb_sr_cmd_seq;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;
    logic       s;
    logic       r;
    logic       busy;
    logic       err;
    logic [2:0] count;

    int  n_tests   = 0;
    int  n_fail    = 0;
    int  pulse_cnt = 0;
    int  hs_cnt    = 0;
    int  excl_hits = 0;
    bit  mon_en    = 0;
    logic s_q      = 1'b0;

    sr_cmd_seq #(.DEPTH(4), .HOLD(2), .GAP(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .s         (s),
        .r         (r),
        .busy      (busy),
        .err       (err),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mid-cycle monitor: exclusion hits, s rising edges, legal handshakes about to land.
    always @(negedge clk) begin
        if (mon_en) begin
            if (s && r)
                excl_hits++;
            if (s && !s_q)
                pulse_cnt++;
            s_q = s;
            if (cmd_valid && cmd_ready && (cmd_op != 2'b11))
                hs_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sr(input string tag, input logic exp_s, input logic exp_r,
                             input logic exp_busy);
        check_eq({tag, ".s"}, 32'(s), 32'(exp_s));
        check_eq({tag, ".r"}, 32'(r), 32'(exp_r));
        check_eq({tag, ".busy"}, 32'(busy), 32'(exp_busy));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pulse0;
        int hs0;
        int max_cnt;
        bit saw_full;
        int waited;

        // Reset held two cycles with a set command offered.
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("rst.ready", 32'(cmd_ready), 0);
            check_eq("rst.count", 32'(count), 0);
            check_eq("rst.err", 32'(err), 0);
            expect_sr("rst", 1'b0, 1'b0, 1'b0);
        end
        mon_en    = 1'b1;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check_eq("rel.ready", 32'(cmd_ready), 1);
        pulse0 = pulse_cnt;
        for (int i = 0; i < 4; i++) step();
        check_eq("rel.pulses", 32'(pulse_cnt - pulse0), 0);
        check_eq("rel.count", 32'(count), 0);

        // Single set: accepted at edge k.
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        step();
        cmd_valid = 1'b0;
        check_eq("set.count_k", 32'(count), 1);
        expect_sr("set.k", 1'b0, 1'b0, 1'b1);
        step(); expect_sr("set.k1", 1'b1, 1'b0, 1'b1);
        check_eq("set.count_k1", 32'(count), 0);
        step(); expect_sr("set.k2", 1'b1, 1'b0, 1'b1);
        step(); expect_sr("set.k3", 1'b0, 1'b0, 1'b1);
        step(); expect_sr("set.k4", 1'b0, 1'b0, 1'b0);

        // Set then reset, back-to-back.
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        step();
        cmd_op = 2'b10;
        step();
        cmd_valid = 1'b0;
        expect_sr("sr.k1", 1'b1, 1'b0, 1'b1);
        check_eq("sr.count_k1", 32'(count), 1);
        step(); expect_sr("sr.k2", 1'b1, 1'b0, 1'b1);
        step(); expect_sr("sr.k3", 1'b0, 1'b0, 1'b1);
        step(); expect_sr("sr.k4", 1'b0, 1'b0, 1'b1);
        check_eq("sr.count_k4", 32'(count), 1);
        step(); expect_sr("sr.k5", 1'b0, 1'b1, 1'b1);
        step(); expect_sr("sr.k6", 1'b0, 1'b1, 1'b1);
        step(); expect_sr("sr.k7", 1'b0, 1'b0, 1'b1);
        step(); expect_sr("sr.k8", 1'b0, 1'b0, 1'b0);

        // Overflow: valid held for 10 cycles.
        pulse0   = pulse_cnt;
        hs0      = hs_cnt;
        max_cnt  = 0;
        saw_full = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        for (int i = 0; i < 10; i++) begin
            step();
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (count == 3'd4) saw_full = 1'b1;
            check_eq("ovf.ready", 32'(cmd_ready), 32'(count != 3'd4));
        end
        cmd_valid = 1'b0;
        check_eq("ovf.max_count", 32'(max_cnt), 4);
        check_eq("ovf.saw_full", 32'(saw_full), 1);
        waited = 0;
        while (busy && waited < 100) begin
            step();
            waited++;
        end
        check_eq("ovf.drain_busy", 32'(busy), 0);
        check_eq("ovf.pulses_vs_hs", 32'(pulse_cnt - pulse0), 32'(hs_cnt - hs0));
        check_eq("ovf.hs_nonzero", 32'(hs_cnt - hs0 > 4), 1);

        // Illegal op: handshake completes, nothing queued, err sticky.
        pulse0    = pulse_cnt;
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        #1;
        check_eq("ill.ready", 32'(cmd_ready), 1);
        step();
        cmd_valid = 1'b0;
        check_eq("ill.err", 32'(err), 1);
        check_eq("ill.count", 32'(count), 0);
        expect_sr("ill.k", 1'b0, 1'b0, 1'b0);
        step(); step();
        check_eq("ill.err_sticky", 32'(err), 1);
        check_eq("ill.pulses", 32'(pulse_cnt - pulse0), 0);

        // Spacer: a silent slot that still occupies the sequencer.
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        step();
        cmd_valid = 1'b0;
        check_eq("spc.count_k", 32'(count), 1);
        expect_sr("spc.k", 1'b0, 1'b0, 1'b1);
        step(); expect_sr("spc.k1", 1'b0, 1'b0, 1'b1);
        check_eq("spc.count_k1", 32'(count), 0);
        step(); expect_sr("spc.k2", 1'b0, 1'b0, 1'b1);
        step(); expect_sr("spc.k3", 1'b0, 1'b0, 1'b1);
        step(); expect_sr("spc.k4", 1'b0, 1'b0, 1'b0);
        check_eq("spc.err_sticky", 32'(err), 1);

        // Mid-pulse reset: queue 01, 10, 01; reset on second cycle of first s pulse.
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        step();
        cmd_op = 2'b10;
        step();
        expect_sr("mid.k1", 1'b1, 1'b0, 1'b1);
        cmd_op = 2'b01;
        step();
        expect_sr("mid.k2", 1'b1, 1'b0, 1'b1);
        check_eq("mid.count_k2", 32'(count), 2);
        cmd_valid = 1'b0;
        rst       = 1'b1;
        #1;
        check_eq("mid.ready_in_rst", 32'(cmd_ready), 0);
        step();
        expect_sr("mid.rst", 1'b0, 1'b0, 1'b0);
        check_eq("mid.count_rst", 32'(count), 0);
        check_eq("mid.err_rst", 32'(err), 0);
        rst    = 1'b0;
        pulse0 = pulse_cnt;
        for (int i = 0; i < 8; i++) step();
        check_eq("mid.no_resume", 32'(pulse_cnt - pulse0), 0);
        expect_sr("mid.after", 1'b0, 1'b0, 1'b0);
        check_eq("mid.count_after", 32'(count), 0);

        check_eq("excl.s_and_r", 32'(excl_hits), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
